// File: rtl/mux_arbiter.sv
// mux_arbiter: registered N-to-1 multiplexer with per-channel valid/ready
// handshakes and a selectable grant policy (external select, fixed priority
// with channel 0 highest, or round-robin). One output register stage with
// full backpressure sits between the producers and the shared consumer.
module mux_arbiter #(
  parameter int Size     = 8,
  parameter int Channels = 8,
  parameter int SelWidth = 3,
  parameter int Mode     = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [SelWidth-1:0]      select_i,
  input  logic [Channels*Size-1:0] data_i,
  input  logic [Channels-1:0]      valid_i,
  output logic [Channels-1:0]      ready_o,
  output logic [Size-1:0]          data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [SelWidth-1:0]      select_o
);

  logic [Channels-1:0] grant;
  logic                hasGrant;
  int                  grantNum;
  int                  scanIdx;
  logic                load;
  logic [SelWidth-1:0] ptr;

  // The register can take a word when it is empty or its word leaves this cycle.
  assign load = ~valid_o | ready_i;

  // Only the granted channel sees ready, and never while in reset or stalled.
  assign ready_o = (reset || !load) ? '0 : grant;

  // Pick one channel according to the grant policy; loops that run downward
  // let the last hit win, which is the first hit in the intended scan order.
  always_comb begin
    grant    = '0;
    hasGrant = 1'b0;
    grantNum = 0;
    scanIdx  = 0;
    if (Mode == 0) begin
      for (int k = 0; k < Channels; k++) begin
        if (select_i == SelWidth'(k) && valid_i[k]) begin
          grant[k] = 1'b1;
          hasGrant = 1'b1;
          grantNum = k;
        end
      end
    end else if (Mode == 1) begin
      for (int k = Channels - 1; k >= 0; k--) begin
        if (valid_i[k]) begin
          grant    = '0;
          grant[k] = 1'b1;
          hasGrant = 1'b1;
          grantNum = k;
        end
      end
    end else begin
      for (int i = Channels - 1; i >= 0; i--) begin
        scanIdx = int'(ptr) + i;
        if (scanIdx >= Channels) scanIdx = scanIdx - Channels;
        if (valid_i[scanIdx]) begin
          grant          = '0;
          grant[scanIdx] = 1'b1;
          hasGrant       = 1'b1;
          grantNum       = scanIdx;
        end
      end
    end
  end

  // Output register and round-robin pointer: load the granted word, drain to
  // empty when nothing is granted, and hold everything while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_o   <= '0;
      valid_o  <= 1'b0;
      select_o <= '0;
      ptr      <= '0;
    end else if (load) begin
      if (hasGrant) begin
        data_o   <= data_i[grantNum*Size +: Size];
        select_o <= SelWidth'(grantNum);
        valid_o  <= 1'b1;
        if (Mode == 2) begin
          ptr <= (grantNum == Channels - 1) ? '0 : SelWidth'(grantNum + 1);
        end
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: three instances (external select with 5 channels, fixed
// priority, round-robin) driven with directed vectors, checked every cycle
// against a behavioural model plus hand-computed expectations.
module tb_mux_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [2:0]  sel0 = 3'd0;
  logic [39:0] data0 = '0;
  logic [4:0]  valid0 = 5'h1F;
  logic        ready0 = 1'b1;
  logic [4:0]  rdy0;
  logic [7:0]  dout0;
  logic        vout0;
  logic [2:0]  sout0;

  logic [2:0]  sel1 = 3'd0;
  logic [63:0] data1 = '0;
  logic [7:0]  valid1 = 8'hFF;
  logic        ready1 = 1'b1;
  logic [7:0]  rdy1;
  logic [7:0]  dout1;
  logic        vout1;
  logic [2:0]  sout1;

  logic [2:0]  sel2 = 3'd0;
  logic [63:0] data2 = '0;
  logic [7:0]  valid2 = 8'hFF;
  logic        ready2 = 1'b1;
  logic [7:0]  rdy2;
  logic [7:0]  dout2;
  logic        vout2;
  logic [2:0]  sout2;

  int compared = 0;
  int mismatched = 0;

  mux_arbiter #(.Size(8), .Channels(5), .SelWidth(3), .Mode(0)) u0 (
    .clock(clock), .reset(reset), .select_i(sel0), .data_i(data0), .valid_i(valid0),
    .ready_o(rdy0), .data_o(dout0), .valid_o(vout0), .ready_i(ready0), .select_o(sout0));

  mux_arbiter #(.Size(8), .Channels(8), .SelWidth(3), .Mode(1)) u1 (
    .clock(clock), .reset(reset), .select_i(sel1), .data_i(data1), .valid_i(valid1),
    .ready_o(rdy1), .data_o(dout1), .valid_o(vout1), .ready_i(ready1), .select_o(sout1));

  mux_arbiter #(.Size(8), .Channels(8), .SelWidth(3), .Mode(2)) u2 (
    .clock(clock), .reset(reset), .select_i(sel2), .data_i(data2), .valid_i(valid2),
    .ready_o(rdy2), .data_o(dout2), .valid_o(vout2), .ready_i(ready2), .select_o(sout2));

  always #5 clock = ~clock;

  // Uniform views of each instance so the model can treat them alike.
  int          cfgMode [3] = '{0, 1, 2};
  int          cfgCh   [3] = '{5, 8, 8};
  logic [31:0] vView   [3];
  logic [63:0] dView   [3];
  logic [2:0]  sView   [3];
  logic        rView   [3];
  logic [31:0] rdyView [3];
  logic [7:0]  doView  [3];
  logic        voView  [3];
  logic [2:0]  soView  [3];

  assign vView[0] = {27'b0, valid0};
  assign vView[1] = {24'b0, valid1};
  assign vView[2] = {24'b0, valid2};
  assign dView[0] = {24'b0, data0};
  assign dView[1] = data1;
  assign dView[2] = data2;
  assign sView[0] = sel0;
  assign sView[1] = sel1;
  assign sView[2] = sel2;
  assign rView[0] = ready0;
  assign rView[1] = ready1;
  assign rView[2] = ready2;
  assign rdyView[0] = {27'b0, rdy0};
  assign rdyView[1] = {24'b0, rdy1};
  assign rdyView[2] = {24'b0, rdy2};
  assign doView[0] = dout0;
  assign doView[1] = dout1;
  assign doView[2] = dout2;
  assign voView[0] = vout0;
  assign voView[1] = vout1;
  assign voView[2] = vout2;
  assign soView[0] = sout0;
  assign soView[1] = sout1;
  assign soView[2] = sout2;

  // Model state: what each output register must hold, plus the rotation start.
  logic [7:0] mData  [3];
  logic       mValid [3];
  int         mSel   [3];
  int         mPtr   [3];
  logic       modelLive = 1'b0;

  // Winning channel under a policy, or -1 when nobody qualifies.
  function automatic int pickChannel(int mode, int ch, logic [31:0] v, int sel, int ptr);
    if (mode == 0) return (sel < ch && v[sel]) ? sel : -1;
    for (int i = 0; i < ch; i++) begin
      int k;
      k = (mode == 2) ? (ptr + i) % ch : i;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic int grantOf(int i);
    return pickChannel(cfgMode[i], cfgCh[i], vView[i], int'(sView[i]), mPtr[i]);
  endfunction

  function automatic logic [31:0] expReady(int i);
    if (reset || !(!mValid[i] || rView[i]) || grantOf(i) < 0) return 32'd0;
    return 32'd1 << grantOf(i);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Advance the model on each rising edge from the inputs the DUT also sees.
  always @(posedge clock) begin
    modelLive <= 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mData[i]  <= 8'd0;
        mValid[i] <= 1'b0;
        mSel[i]   <= 0;
        mPtr[i]   <= 0;
      end else if (!mValid[i] || rView[i]) begin
        if (grantOf(i) >= 0) begin
          mData[i]  <= dView[i][grantOf(i)*8 +: 8];
          mSel[i]   <= grantOf(i);
          mValid[i] <= 1'b1;
          mPtr[i]   <= (grantOf(i) + 1) % cfgCh[i];
        end else begin
          mValid[i] <= 1'b0;
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clock) begin
    if (modelLive) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("u%0d ready_o", i), rdyView[i], expReady(i));
        checkOutput($sformatf("u%0d valid_o", i), 32'(voView[i]), 32'(mValid[i]));
        checkOutput($sformatf("u%0d data_o", i), 32'(doView[i]), 32'(mData[i]));
        checkOutput($sformatf("u%0d select_o", i), 32'(soView[i]), 32'(mSel[i]));
      end
    end
  end

  // Directed scenarios with literal expectations.
  initial begin
    int rrSeq [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 7, 0, 7};

    // Reset with every valid high: nothing may be accepted.
    applyStimulus(1);
    checkOutput("reset ready_o u1", 32'(rdy1), 32'd0);
    checkOutput("reset ready_o u0", 32'(rdy0), 32'd0);
    applyStimulus(1);
    checkOutput("reset valid_o u2", 32'(vout2), 32'd0);
    checkOutput("reset data_o u1", 32'(dout1), 32'd0);
    checkOutput("reset select_o u2", 32'(sout2), 32'd0);
    valid0 = '0;
    valid1 = '0;
    valid2 = '0;
    reset  = 1'b0;
    applyStimulus(1);

    // External select: in-range channel passes, out-of-range grants nobody.
    data0  = 40'h44_A5_33_22_11;
    sel0   = 3'd3;
    valid0 = 5'b01000;
    #1 checkOutput("m0 ready_o sel3", 32'(rdy0), 32'h08);
    applyStimulus(1);
    checkOutput("m0 data_o sel3", 32'(dout0), 32'hA5);
    checkOutput("m0 select_o sel3", 32'(sout0), 32'd3);
    checkOutput("m0 valid_o sel3", 32'(vout0), 32'd1);
    sel0   = 3'd6;
    valid0 = 5'h1F;
    #1 checkOutput("m0 ready_o sel6", 32'(rdy0), 32'd0);
    applyStimulus(1);
    checkOutput("m0 valid_o drained", 32'(vout0), 32'd0);
    checkOutput("m0 data_o held", 32'(dout0), 32'hA5);
    valid0 = '0;

    // Fixed priority: channel 2 wins over 5 and 7 until it drops.
    data1  = 64'h17_16_15_14_13_12_11_10;
    valid1 = 8'b1010_0100;
    #1 checkOutput("m1 ready_o ch2", 32'(rdy1), 32'h04);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1);
      checkOutput("m1 select_o ch2", 32'(sout1), 32'd2);
      checkOutput("m1 data_o ch2", 32'(dout1), 32'h12);
    end
    valid1 = 8'b1010_0000;
    #1 checkOutput("m1 ready_o ch5", 32'(rdy1), 32'h20);
    applyStimulus(1);
    checkOutput("m1 select_o ch5", 32'(sout1), 32'd5);
    valid1 = '0;
    applyStimulus(1);

    // Round-robin: full rotation with wrap, then alternating between 0 and 7.
    data2  = 64'h27_26_25_24_23_22_21_20;
    valid2 = 8'hFF;
    for (int c = 0; c < 12; c++) begin
      if (c == 9) valid2 = 8'b1000_0001;
      applyStimulus(1);
      checkOutput($sformatf("m2 rr step %0d", c), 32'(sout2), 32'(rrSeq[c]));
    end
    checkOutput("m2 data_o ch7", 32'(dout2), 32'h27);
    valid2 = '0;
    applyStimulus(1);

    // Backpressure: stalled word holds, then swap with no bubble.
    data1  = 64'h0000_0000_0000_5A3C;
    valid1 = 8'b01;
    applyStimulus(1);
    checkOutput("bp data_o loaded", 32'(dout1), 32'h3C);
    ready1 = 1'b0;
    valid1 = 8'b10;
    for (int c = 0; c < 3; c++) begin
      #1 checkOutput("bp ready_o stalled", 32'(rdy1), 32'd0);
      applyStimulus(1);
      checkOutput("bp data_o held", 32'(dout1), 32'h3C);
    end
    ready1 = 1'b1;
    #1 checkOutput("bp ready_o resume", 32'(rdy1), 32'h02);
    applyStimulus(1);
    checkOutput("bp data_o swap", 32'(dout1), 32'h5A);
    checkOutput("bp valid_o swap", 32'(vout1), 32'd1);
    valid1 = '0;
    applyStimulus(1);

    // Reset mid-stream drops the held word and rewinds the rotation.
    valid2 = 8'b0001_0100;
    applyStimulus(1);
    checkOutput("rst pre select_o", 32'(sout2), 32'd2);
    ready2 = 1'b0;
    applyStimulus(1);
    reset = 1'b1;
    #1 checkOutput("rst ready_o gated", 32'(rdy2), 32'd0);
    applyStimulus(1);
    checkOutput("rst valid_o dropped", 32'(vout2), 32'd0);
    reset  = 1'b0;
    ready2 = 1'b1;
    #1 checkOutput("rst ready_o lowest", 32'(rdy2), 32'h04);
    applyStimulus(1);
    checkOutput("rst first grant", 32'(sout2), 32'd2);
    valid2 = '0;
    applyStimulus(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Parametrised, registered N-to-1 multiplexer with per-channel valid/ready handshakes. It generalises the fixed-width combinational muxes to any channel count and adds three selection modes: external select, fixed priority and round-robin. It has one output register stage with full backpressure. It sits between multiple producers and one shared consumer, such as a bus or FIFO write port.

## Interface
- Size, 8, data width per channel in bits
- Channels, 8, number of input channels (2..32)
- SelWidth, 3, width of select_i/select_o; must satisfy 2**SelWidth >= Channels
- Mode, 1, 0 = external select, 1 = fixed priority (channel 0 highest), 2 = round-robin

Ports (one clock; reset is synchronous and active-high):
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- select_i  input  SelWidth  channel to pass in Mode 0; ignored otherwise
- data_i  input  Channels*Size  packed inputs; channel k occupies bits [k*Size +: Size]
- valid_i  input  Channels  per-channel data valid
- ready_o  output  Channels  per-channel accept; one-hot or zero
- data_o  output  Size  registered output data
- valid_o  output  1  output holds valid data
- ready_i  input  1  consumer accepts data_o this cycle
- select_o  output  SelWidth  channel index that data_o came from

## Operation
- load = ~valid_o | ready_i. The output register can take new data this cycle when load is high.
- grant is a combinational one-hot over channels:
  - Mode 0: grant[select_i] = valid_i[select_i]. If select_i >= Channels, there is no grant.
  - Mode 1: grant goes to the lowest index k with valid_i[k] = 1.
  - Mode 2: grant goes to the first k with valid_i[k] = 1, scanning from ptr upward modulo Channels.
- ready_o = grant & {Channels{load}}. A transfer on channel k happens when valid_i[k] & ready_o[k]. At most one transfer per cycle.
- On a transfer from channel k: data_o <= data_i[k], select_o <= k, valid_o <= 1.
- If load = 1 and there is no grant: valid_o <= 0. data_o and select_o hold.
- If load = 0: all outputs hold. Producers must hold valid_i and data until accepted.
- Round-robin pointer ptr (SelWidth bits), Mode 2 only:
  - After a transfer from channel k, ptr <= k+1, wrapping to 0 when k = Channels-1.
  - ptr is unchanged when there is no transfer.
- ptr is unused in Modes 0 and 1.
- Reset dominates all other events. During reset, ready_o = 0 regardless of valid_i.

## Timing
- Reset values: data_o = 0, valid_o = 0, select_o = 0, ptr = 0.
- Latency is 1 cycle: data accepted at edge n appears on data_o after edge n.
- Throughput is one word per cycle while ready_i = 1 and any eligible valid_i is high.
- Simultaneous ready_i = 1 and a new grant: the old word is consumed and the new word is loaded on the same edge. There is no bubble.
- ready_o depends combinationally on valid_i, select_i, valid_o, ready_i and ptr. There is no combinational path from data_i to any output.
- Reset asserted mid-transfer: the word held in the register is dropped and valid_o = 0 on the next cycle. Input words presented during reset are not accepted.

## Test plan
- Reset and idle:
  - Stimulus: reset for 2 cycles with valid_i = 8'hFF.
  - Required: data_o = 0, valid_o = 0, select_o = 0, ready_o = 0 throughout reset.
- Mode 0, out-of-range select (Channels = 5, SelWidth = 3):
  - select_i = 3 with channel 3 data 8'hA5 -> data_o = 8'hA5, select_o = 3, valid_o = 1 one cycle later.
  - select_i = 6 -> ready_o = 0, and valid_o falls to 0 once consumed.
- Mode 1, fixed priority:
  - valid_i = 8'b1010_0100 held, ready_i = 1.
  - Required: channel 2 is granted every cycle; channels 5 and 7 get no ready_o until valid_i[2] drops.
- Mode 2, round-robin:
  - All 8 valid_i held high, ready_i = 1.
  - Required: select_o sequence is 0,1,…,7,0 and the pointer wraps.
  - With valid_i = 8'b1000_0001, the sequence is 0,7,0,7.
- Backpressure:
  - Load 8'h3C, then ready_i = 0 for 3 cycles while valid_i[1] = 1.
  - Required: data_o stays 8'h3C, ready_o = 0.
  - Then ready_i = 1 -> channel 1 is accepted on the same edge, data_o updates next cycle with no bubble.
- Reset mid-stream:
  - Assert reset while valid_o = 1 and ready_i = 0.
  - Required: next cycle valid_o = 0 and ptr = 0; the first grant after reset in Mode 2 is the lowest valid channel.
